// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: datapath width, fetch queue entry layout
// and default fetch queue depth.
package mips_pkg;

  localparam int DATA_W        = 32;
  localparam int FETCH_Q_DEPTH = 4;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x W register array with one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module fetch_queue_mem
  import mips_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int W     = 2 * DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// IF/ID prefetch FIFO of {pc, instr} pairs with valid/ready on both sides and flush.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency empty-queue pass-through path.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH  = FETCH_Q_DEPTH,
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_pc,
  input  logic [DATA_W-1:0]      in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_pc,
  output logic [DATA_W-1:0]      out_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;

  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [2*DATA_W-1:0] rd_data;
  logic                push;
  logic                pop;
  logic                bypass;
  logic                push_q;
  logic                pop_q;
  logic                wr_en;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid & in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & in_valid & !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !empty | bypass;
  assign pop       = out_valid & out_ready;

  // A bypassed word that decode takes immediately never enters storage.
  assign pop_q  = pop & !empty;
  assign push_q = push & !(bypass & out_ready);
  assign wr_en  = push_q & !flush;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (2 * DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (!empty) begin
      {out_pc, out_instr} = rd_data;
    end else if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end

  // Flush outranks push and pop; pointers wrap naturally at ADDR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_q) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_q)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_q, pop_q})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model.
module tb_fetch_queue;
  import mips_pkg::*;

  localparam int DEPTH = FETCH_Q_DEPTH;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_pc;
  logic [31:0]            in_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [31:0]            out_instr;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  fetch_entry_t q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered list of entries, updated from the rules at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      automatic int  n    = q.size();
      automatic bit  do_pop  = (n > 0) && out_ready;
      automatic bit  do_push = in_valid && (n < DEPTH);
      automatic bit  direct  = BYP && (n == 0) && in_valid && out_ready;
      automatic fetch_entry_t e;
      e.pc    = in_pc;
      e.instr = in_instr;
      if (do_pop) void'(q.pop_front());
      if (do_push && !direct) q.push_back(e);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      automatic int n   = q.size();
      automatic bit byp = BYP && (n == 0) && in_valid && !flush;
      automatic logic [31:0] epc = (n > 0) ? q[0].pc    : (byp ? in_pc    : 32'd0);
      automatic logic [31:0] ein = (n > 0) ? q[0].instr : (byp ? in_instr : 32'd0);
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
      chk("out_valid", 32'(out_valid), 32'((n > 0) || byp));
      chk("out_pc", out_pc, epc);
      chk("out_instr", out_instr, ein);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_pc    = base + 32'(4 * i);
      in_instr = ~(base + 32'(4 * i));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_pc", out_pc, 32'd0);
    rst = 1'b0;
    step();

    // Empty queue, word offered with decode ready.
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hAAAA_0100; out_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_out_valid", 32'(out_valid), 32'd1);
    chk("byp_out_pc", out_pc, 32'h100);
    step();
    in_valid = 1'b0;
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nobyp_out_valid0", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("nobyp_out_valid1", 32'(out_valid), 32'd1);
    chk("nobyp_out_pc1", out_pc, 32'h100);
`endif
    step();
    chk("byp_empty_after", 32'(empty), 32'd1);

    // Fill then drain in order.
    out_ready = 1'b0;
    push_n(4, 32'h0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(4 * i));
      step();
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push/pop at count 2.
    out_ready = 1'b0;
    push_n(2, 32'h200);
    in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'h1010; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pp_count", 32'(count), 32'd2);
    chk("pp_head", out_pc, 32'h204);
    step();
    chk("pp_new_head", out_pc, 32'h10);
    drain();

    // Flush with a concurrent push.
    out_ready = 1'b0;
    push_n(3, 32'h300);
    in_valid = 1'b1; in_pc = 32'h20; in_instr = 32'h2020; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    push_n(1, 32'h40);
    chk("flush_next_head", out_pc, 32'h40);
    chk("flush_next_count", 32'(count), 32'd1);
    drain();

    // Full queue with pop and a refused push in the same cycle.
    out_ready = 1'b0;
    push_n(4, 32'h500);
    in_valid = 1'b1; in_pc = 32'h600; in_instr = 32'h6060; out_ready = 1'b1;
    #1;
    chk("fullpop_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_head", out_pc, 32'h504);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("fullpop_refill", 32'(count), 32'd4);
    drain();

    // Wrap-around over 3*DEPTH transactions.
    out_ready = 1'b1;
    push_n(3 * DEPTH, 32'h700);
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    push_n(3, 32'h800);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Randomized traffic with upstream holding pc while refused.
    for (int i = 0; i < 600; i++) begin
      automatic int bias = (i < 300) ? 30 : 75;
      if (!(in_valid && q.size() == DEPTH)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc    = $urandom;
        in_instr = $urandom;
      end
      out_ready = ($urandom_range(0, 99) < bias);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small prefetch FIFO between the PC register / instruction-memory read and the decode stage (IF/ID boundary).
- Buffers {pc, instr} pairs so fetch keeps running while decode stalls.
- Discards all buffered entries on a branch/jump flush.
- Valid/ready handshake on both sides.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.
- DATA_W, 32, width of both the pc and the instr fields.

Ports:
- clk        input   1       rising-edge clock
- rst        input   1       asynchronous reset, active-high
- flush      input   1       synchronous discard of all entries (branch/jump taken)
- in_valid   input   1       fetch presents pc/instr
- in_ready   output  1       queue accepts push
- in_pc      input   DATA_W  PC of fetched instruction
- in_instr   input   DATA_W  instruction word from instruction memory
- out_valid  output  1       head entry available to decode
- out_ready  input   1       decode consumes head
- out_pc     output  DATA_W  head PC
- out_instr  output  DATA_W  head instruction
- count      output  ADDR_W+1  current occupancy, 0..DEPTH
- full       output  1       count == DEPTH
- empty      output  1       count == 0

Behaviour:
- Clock is clk. Reset is rst: asynchronous and active-high.
- Reset, applied at any time including mid-operation, forces:
  - read and write pointers = 0, count = 0
  - out_valid = 0, empty = 1, full = 0, in_ready = 1
  - out_pc = 0, out_instr = 0
- Storage array is not reset.
- Handshake signals:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = !full; no push into a full queue, even when a pop happens in the same cycle.
- Push: write {in_pc, in_instr} at wr_ptr on the clock edge; wr_ptr increments.
- Pop: rd_ptr increments on the clock edge.
- Pointers wrap modulo DEPTH naturally (ADDR_W bits).
- count update per edge:
  - +1 on push only
  - -1 on pop only
  - unchanged when push and pop coincide (non-empty, non-full).
- Outputs are read combinationally from the head entry at rd_ptr:
  - out_valid = !empty
  - out_pc and out_instr are forced to 0 while empty.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N (1 cycle).
- Flush, at the clock edge:
  - rd_ptr = wr_ptr = 0, count = 0
  - a push in the same cycle is discarded
  - a pop in the same cycle is irrelevant
  - flush has priority over push and pop.
- While flush is high, in_ready still follows !full; out_valid still reflects current contents until the edge.
- Single-entry boundary (count == 1) with push and pop together: the new entry becomes head; count stays 1.
- in_valid while full: held off by in_ready = 0; upstream must keep PC stable.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty, in_valid = 1 and flush = 0:
  - out_valid = 1 and out_pc/out_instr = in_pc/in_instr combinationally (0-cycle latency).
  - If out_ready = 1: the word is consumed directly, not written; count stays 0.
  - If out_ready = 0: the word is written normally.
- Not defined: no combinational in-to-out path; minimum latency is 1 cycle as above.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W = 32
  - fetch_entry_t struct {pc, instr}
  - FETCH_Q_DEPTH default constant.
- One sub-module: fetch_queue_mem, a DEPTH x 2*DATA_W register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic stay in fetch_queue.

Test Plan:
- Reset mid-stream: 3 entries loaded, assert rst asynchronously between edges -> count = 0, out_valid = 0, out_pc = 0 immediately, before the next edge.
- Fill/drain: push pc = 0x0, 0x4, 0x8, 0xC with out_ready = 0 -> full = 1, in_ready = 0, count = 4; then out_ready = 1 -> out_pc 0x0, 0x4, 0x8, 0xC on four successive cycles, then empty = 1.
- Simultaneous push/pop at count = 2, pushing pc = 0x10 -> count stays 2; wrap-around verified across 3×DEPTH transactions with ordering intact.
- Flush with in_valid = 1 (pc = 0x20) at count = 3 -> count = 0 after the edge; 0x20 is not stored; next push 0x40 appears as head.
- Full + pop same cycle, in_valid = 1 -> push refused, count goes 4 -> 3, upstream pc held.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty, in_pc = 0x100, out_ready = 1 -> out_valid = 1 and out_pc = 0x100 in the same cycle; count stays 0. Without the macro: out_valid is first seen the next cycle.
